vend_sequencer: RTL and testbench

Top-level transaction controller for the vending machine. Accepts coin pulses, accumulates credit, and decides when to dispense. It times the dispense and ending phases and selects the 16-bit word that drives the display path. It owns the message-select lines for the per-phase message blocks, including the ending pattern 16'h00FF.

---
 rtl/vend_sequencer.sv | 135 +++++++++++++
 tb/tb_vend_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending transaction controller: credit, vend decision, timed dispense/ending phases
module vend_sequencer #(
   parameter int               CNT_W       = 27,
   parameter logic [7:0]       PRICE       = 8'd15,
   parameter logic [CNT_W-1:0] HOLD_CYCLES = 27'd100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        coin_in,
   input  logic [7:0]  coin_val,
   input  logic        cancel,
   output logic [15:0] disp_word,
   output logic [1:0]  msg_sel,
   output logic [7:0]  credit,
   output logic [7:0]  change,
   output logic        dispense,
   output logic        coin_reject,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COLLECT  = 2'd1,
      S_DISPENSE = 2'd2,
      S_ENDING   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_CYCLES - ONE;

   state_t           r_state;
   logic [CNT_W-1:0] r_timer;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_timer_nxt;
   logic [7:0]       w_credit_nxt;
   logic [7:0]       w_change_nxt;
   logic             w_dispense_nxt;
   logic             w_reject_nxt;
   logic [15:0]      w_disp_nxt;
   logic [8:0]       w_sum;
   logic [7:0]       w_sat;
   logic             w_vend;
   logic             w_timer_done;

   // IDLE starts from zero credit, so the same saturating sum serves both states
   always_comb begin
      w_sum        = (r_state == S_COLLECT) ? ({1'b0, credit} + {1'b0, coin_val})
                                            : {1'b0, coin_val};
      w_sat        = w_sum[8] ? 8'hFF : w_sum[7:0];
      w_vend       = (w_sat >= PRICE);
      w_timer_done = (r_timer == HOLD_LAST);
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_timer_nxt    = '0;
      w_credit_nxt   = credit;
      w_change_nxt   = change;
      w_dispense_nxt = 1'b0;
      w_reject_nxt   = 1'b0;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            if (r_state == S_COLLECT && cancel) begin
               w_state_nxt  = S_ENDING;
               w_change_nxt = credit;
               w_credit_nxt = 8'h00;
               w_reject_nxt = coin_in;
            end else if (coin_in) begin
               if (w_vend) begin
                  w_state_nxt    = S_DISPENSE;
                  w_change_nxt   = w_sat - PRICE;
                  w_credit_nxt   = 8'h00;
                  w_dispense_nxt = 1'b1;
               end else begin
                  w_state_nxt  = S_COLLECT;
                  w_credit_nxt = w_sat;
               end
            end
         end
         S_DISPENSE: begin
            w_reject_nxt = coin_in;
            if (w_timer_done) w_state_nxt = S_ENDING;
            else              w_timer_nxt = r_timer + ONE;
         end
         S_ENDING: begin
            w_reject_nxt = coin_in;
            if (w_timer_done) begin
               w_state_nxt  = S_IDLE;
               w_change_nxt = 8'h00;
               w_credit_nxt = 8'h00;
            end else begin
               w_timer_nxt = r_timer + ONE;
            end
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_change_nxt = 8'h00;
            w_credit_nxt = 8'h00;
         end
      endcase

      case (w_state_nxt)
         S_COLLECT:  w_disp_nxt = {8'h00, w_credit_nxt};
         S_DISPENSE: w_disp_nxt = {8'hD0, w_change_nxt};
         S_ENDING:   w_disp_nxt = 16'h00FF;
         default:    w_disp_nxt = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         credit      <= 8'h00;
         change      <= 8'h00;
         dispense    <= 1'b0;
         coin_reject <= 1'b0;
         busy        <= 1'b0;
         msg_sel     <= 2'd0;
         disp_word   <= 16'h0000;
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= w_timer_nxt;
         credit      <= w_credit_nxt;
         change      <= w_change_nxt;
         dispense    <= w_dispense_nxt;
         coin_reject <= w_reject_nxt;
         busy        <= (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_ENDING);
         msg_sel     <= w_state_nxt;
         disp_word   <= w_disp_nxt;
      end
   end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed and random checks of vend_sequencer against a phase/countdown reference model
module tb_vend_sequencer;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        coin_in;
   logic [7:0]  coin_val;
   logic        cancel;

   logic [15:0] a_word,  b_word;
   logic [1:0]  a_msg,   b_msg;
   logic [7:0]  a_cred,  b_cred;
   logic [7:0]  a_chg,   b_chg;
   logic        a_disp,  b_disp;
   logic        a_rej,   b_rej;
   logic        a_busy,  b_busy;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   vend_sequencer #(.CNT_W(27), .PRICE(8'd15), .HOLD_CYCLES(27'd4)) dut (
      .clk(clk), .rst(rst), .coin_in(coin_in), .coin_val(coin_val), .cancel(cancel),
      .disp_word(a_word), .msg_sel(a_msg), .credit(a_cred), .change(a_chg),
      .dispense(a_disp), .coin_reject(a_rej), .busy(a_busy));

   vend_sequencer #(.CNT_W(27), .PRICE(8'hFF), .HOLD_CYCLES(27'd4)) dut_sat (
      .clk(clk), .rst(rst), .coin_in(coin_in), .coin_val(coin_val), .cancel(cancel),
      .disp_word(b_word), .msg_sel(b_msg), .credit(b_cred), .change(b_chg),
      .dispense(b_disp), .coin_reject(b_rej), .busy(b_busy));

   // phase: 0 idle, 1 collecting, 2 dispensing, 3 ending; left = cycles remaining in a timed phase
   typedef struct packed {
      logic [1:0] phase;
      logic [7:0] left;
      logic [7:0] credit;
      logic [7:0] change;
      logic       disp;
      logic       rej;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m = '0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, logic c, logic [7:0] v, logic x, int price);
      mdl_t n;
      int   s;
      n      = m;
      n.disp = 1'b0;
      n.rej  = 1'b0;
      if (m.phase == 2'd1 && x) begin
         n.change = m.credit;
         n.credit = 8'd0;
         n.phase  = 2'd3;
         n.left   = 8'(HOLD);
         n.rej    = c;
      end else if (m.phase <= 2'd1) begin
         if (c) begin
            s = int'(v) + ((m.phase == 2'd1) ? int'(m.credit) : 0);
            if (s > 255) s = 255;
            if (s >= price) begin
               n.phase  = 2'd2;
               n.left   = 8'(HOLD);
               n.change = 8'(s - price);
               n.credit = 8'd0;
               n.disp   = 1'b1;
            end else begin
               n.phase  = 2'd1;
               n.credit = 8'(s);
            end
         end
      end else begin
         n.rej  = c;
         n.left = m.left - 8'd1;
         if (n.left == 8'd0) begin
            if (m.phase == 2'd2) begin
               n.phase = 2'd3;
               n.left  = 8'(HOLD);
            end else begin
               n.phase  = 2'd0;
               n.credit = 8'd0;
               n.change = 8'd0;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [15:0] mdl_word(mdl_t m);
      case (m.phase)
         2'd1:    return {8'h00, m.credit};
         2'd2:    return {8'hD0, m.change};
         2'd3:    return 16'h00FF;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string nm, input mdl_t m, input logic [15:0] w,
                            input logic [1:0] ms, input logic [7:0] cr, input logic [7:0] ch,
                            input logic d, input logic r, input logic b);
      chk({nm, ".disp_word"},   w,            mdl_word(m));
      chk({nm, ".msg_sel"},     {14'd0, ms},  {14'd0, m.phase});
      chk({nm, ".credit"},      {8'd0, cr},   {8'd0, m.credit});
      chk({nm, ".change"},      {8'd0, ch},   {8'd0, m.change});
      chk({nm, ".dispense"},    {15'd0, d},   {15'd0, m.disp});
      chk({nm, ".coin_reject"}, {15'd0, r},   {15'd0, m.rej});
      chk({nm, ".busy"},        {15'd0, b},   {15'd0, m.phase[1]});
   endtask

   task automatic cyc(input logic c, input logic [7:0] v, input logic x, input logic r);
      coin_in  = c;
      coin_val = v;
      cancel   = x;
      rst      = r;
      @(posedge clk);
      if (r) begin
         ma = mdl_reset();
         mb = mdl_reset();
      end else begin
         ma = mdl_step(ma, c, v, x, 15);
         mb = mdl_step(mb, c, v, x, 255);
      end
      #1;
      check_dut("a", ma, a_word, a_msg, a_cred, a_chg, a_disp, a_rej, a_busy);
      check_dut("b", mb, b_word, b_msg, b_cred, b_chg, b_disp, b_rej, b_busy);
      coin_in = 1'b0;
      cancel  = 1'b0;
      rst     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, 1'b0);
   endtask

   initial begin
      logic       rc, rx, rr;
      logic [7:0] rv;
      rst = 1'b1; coin_in = 1'b0; coin_val = 8'd0; cancel = 1'b0;
      ma = mdl_reset();
      mb = mdl_reset();

      cyc(1'b0, 8'd0, 1'b0, 1'b1);
      cyc(1'b0, 8'd0, 1'b0, 1'b1);
      chk("reset.disp_word", a_word, 16'h0000);
      idle(10);

      // exact payment
      cyc(1'b1, 8'd5, 1'b0, 1'b0);
      chk("exact.credit5", {8'd0, a_cred}, 16'd5);
      cyc(1'b1, 8'd5, 1'b0, 1'b0);
      cyc(1'b1, 8'd5, 1'b0, 1'b0);
      chk("exact.word", a_word, 16'hD000);
      chk("exact.pulse", {15'd0, a_disp}, 16'd1);
      idle(10);

      // reset wins mid-dispense
      cyc(1'b1, 8'd20, 1'b0, 1'b0);
      idle(1);
      cyc(1'b0, 8'd0, 1'b0, 1'b1);
      chk("midreset.msg_sel", {14'd0, a_msg}, 16'd0);
      idle(2);

      // overpayment
      cyc(1'b1, 8'd10, 1'b0, 1'b0);
      cyc(1'b1, 8'd25, 1'b0, 1'b0);
      chk("overpay.word", a_word, 16'hD014);
      idle(10);

      // cancel, then cancel together with a coin
      cyc(1'b1, 8'd10, 1'b0, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      chk("cancel.change", {8'd0, a_chg}, 16'd10);
      idle(10);
      cyc(1'b1, 8'd7, 1'b0, 1'b0);
      cyc(1'b1, 8'd3, 1'b1, 1'b0);
      chk("cancel_coin.change", {8'd0, a_chg}, 16'd7);
      idle(10);

      // coins while busy
      cyc(1'b1, 8'd15, 1'b0, 1'b0);
      cyc(1'b1, 8'd9, 1'b0, 1'b0);
      idle(2);
      cyc(1'b0, 8'd0, 1'b0, 1'b0);
      cyc(1'b1, 8'd9, 1'b1, 1'b0);
      idle(10);

      // saturation on the PRICE=FF instance
      cyc(1'b0, 8'd0, 1'b0, 1'b1);
      cyc(1'b1, 8'd200, 1'b0, 1'b0);
      cyc(1'b1, 8'd200, 1'b0, 1'b0);
      chk("sat.word", b_word, 16'hD000);
      chk("sat.msg_sel", {14'd0, b_msg}, 16'd2);
      idle(10);

      for (int i = 0; i < 600; i++) begin
         rr = ($urandom_range(0, 99) < 2);
         rc = ($urandom_range(0, 2) == 0);
         rv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 12));
         rx = ($urandom_range(0, 7) == 0);
         cyc(rc, rv, rx, rr);
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
